// File: rtl/texture_pkg.sv
// Shared types and constants for the texture storage/fetch unit.
package texture_pkg;

  localparam int ADDR_W  = 17;
  localparam int TEXEL_W = 32;
  localparam int CH_W    = 8;

  localparam int R_LSB = 24;
  localparam int G_LSB = 16;
  localparam int B_LSB = 8;
  localparam int A_LSB = 0;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
    logic [CH_W-1:0] a;
  } rgba_t;

  function automatic rgba_t to_rgba(input logic [TEXEL_W-1:0] w);
    rgba_t t;
    t.r = w[R_LSB +: CH_W];
    t.g = w[G_LSB +: CH_W];
    t.b = w[B_LSB +: CH_W];
    t.a = w[A_LSB +: CH_W];
    return t;
  endfunction

endpackage

// File: rtl/texture_ram.sv
// Texel RAM: one synchronous write port, one registered read-first read port.
module texture_ram
  import texture_pkg::*;
#(
  parameter int MEM_DEPTH = 16384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [TEXEL_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output rgba_t              rd_data
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  logic [TEXEL_W-1:0] mem [MEM_DEPTH];
  rgba_t rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (we && (wr_addr < DEPTH_A)) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Read sees the array before this edge's write lands, giving read-first.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = (rd_addr < DEPTH_A) ? to_rgba(mem[rd_addr[IDX_W-1:0]]) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/texture_controller.sv
// Texture slot select, texel pointer stepping and fetch into the RGBA output register.
// Optional build macro TEXCTRL_PIXEL_WRAP_EN keeps the pointer inside the current slot.
module texture_controller
  import texture_pkg::*;
#(
  parameter int TEX_WORDS = 50,
  parameter int MEM_DEPTH = 16384
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         TexNum,
  input  logic               load_texture,
  input  logic               get_rgba,
  input  logic               write,
  input  logic [ADDR_W-1:0]  write_address,
  input  logic [TEXEL_W-1:0] write_data,
  output logic [CH_W-1:0]    red,
  output logic [CH_W-1:0]    green,
  output logic [CH_W-1:0]    blue,
  output logic [CH_W-1:0]    alpha
);

  localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(TEX_WORDS);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] base_sel, ptr_inc, ptr_next;
  logic [7:0]        tex_m1;
  rgba_t             texel;

`ifdef TEXCTRL_PIXEL_WRAP_EN
  localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(TEX_WORDS - 1);
  logic [ADDR_W-1:0] base_q, base_d;
`else
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
`endif

  always_comb begin
    // TexNum 0 aliases slot 1
    tex_m1   = (TexNum == 8'd0) ? 8'd0 : TexNum - 8'd1;
    base_sel = ADDR_W'(tex_m1) * WORDS_A;
    ptr_inc  = ptr_q + ONE_A;
`ifdef TEXCTRL_PIXEL_WRAP_EN
    ptr_next = (ptr_q == base_q + LAST_OFS) ? base_q : ptr_inc;
    base_d   = base_q;
`else
    ptr_next = (ptr_inc >= DEPTH_A) ? '0 : ptr_inc;
`endif
    ptr_d     = ptr_q;
    pending_d = 1'b0;
    if (load_texture) begin
      ptr_d     = base_sel;
      pending_d = 1'b1;
`ifdef TEXCTRL_PIXEL_WRAP_EN
      base_d    = base_sel;
`endif
    end else if (get_rgba) begin
      ptr_d     = ptr_next;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      pending_q <= 1'b0;
`ifdef TEXCTRL_PIXEL_WRAP_EN
      base_q    <= '0;
`endif
    end else begin
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
`ifdef TEXCTRL_PIXEL_WRAP_EN
      base_q    <= base_d;
`endif
    end
  end

  // The RAM read register doubles as the channel output register.
  texture_ram #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .we      (write),
    .wr_addr (write_address),
    .wr_data (write_data),
    .rd_en   (pending_q),
    .rd_addr (ptr_q),
    .rd_data (texel)
  );

  assign red   = texel.r;
  assign green = texel.g;
  assign blue  = texel.b;
  assign alpha = texel.a;

endmodule

// File: tb/tb_texture_controller.sv
// Self-checking bench for texture_controller: vector table, scoreboard and corner sequences.
module tb_texture_controller;

  localparam int TEX_WORDS = 50;
  localparam int MEM_DEPTH = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  TexNum = 8'd0;
  logic        load_texture = 1'b0;
  logic        get_rgba = 1'b0;
  logic        write = 1'b0;
  logic [16:0] write_address = '0;
  logic [31:0] write_data = '0;
  logic [7:0]  red, green, blue, alpha;

  texture_controller #(
    .TEX_WORDS (TEX_WORDS),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .TexNum        (TexNum),
    .load_texture  (load_texture),
    .get_rgba      (get_rgba),
    .write         (write),
    .write_address (write_address),
    .write_data    (write_data),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .alpha         (alpha)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] mm [MEM_DEPTH];
  int          ptr_m = 0;
  int          base_m = 0;
  logic [31:0] sbq [$];
  bit          due = 1'b0;

  typedef struct {
    string       name;
    logic [7:0]  tex;
    logic        ld;
    logic        gt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: dut=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int base_of(input logic [7:0] t);
    int n;
    n = (t == 8'd0) ? 1 : int'(t);
    return (n - 1) * TEX_WORDS;
  endfunction

  function automatic int next_of(input int p);
`ifdef TEXCTRL_PIXEL_WRAP_EN
    return (p == base_m + TEX_WORDS - 1) ? base_m : p + 1;
`else
    return (p + 1) % MEM_DEPTH;
`endif
  endfunction

  function automatic logic [31:0] rd_m(input int p);
    return (p < MEM_DEPTH) ? mm[p] : 32'h0;
  endfunction

  function automatic logic [31:0] dut_word();
    return {red, green, blue, alpha};
  endfunction

  // One clock edge: model the edge, then compare any fetch that completed on it.
  task automatic tick();
    logic [31:0] e;
    bit          do_chk;
    do_chk = 1'b0;
    e = '0;
    @(posedge clk);
    if (!reset) begin
      if (due) begin
        e = sbq.pop_front();
        due = 1'b0;
        do_chk = 1'b1;
      end
      if (write && (int'(write_address) < MEM_DEPTH)) mm[int'(write_address)] = write_data;
      if (load_texture) begin
        base_m = base_of(TexNum);
        ptr_m  = base_m;
        sbq.push_back(rd_m(ptr_m));
        due = 1'b1;
      end else if (get_rgba) begin
        ptr_m = next_of(ptr_m);
        sbq.push_back(rd_m(ptr_m));
        due = 1'b1;
      end
    end
    #1;
    if (do_chk) chk("scoreboard", dut_word(), e);
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    write = 1'b1;
    write_address = 17'(addr);
    write_data = data;
    tick();
    write = 1'b0;
  endtask

  task automatic model_reset();
    sbq.delete();
    due = 1'b0;
    ptr_m = 0;
    base_m = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: dut=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mm[i] = '0;

    vecs[0] = '{name: "tex1_load",  tex: 8'd1, ld: 1'b1, gt: 1'b0, exp: 32'hFFFFFFFF};
    vecs[1] = '{name: "tex0_as_1",  tex: 8'd0, ld: 1'b1, gt: 1'b0, exp: 32'hFFFFFFFF};
    vecs[2] = '{name: "tex2_load",  tex: 8'd2, ld: 1'b1, gt: 1'b0, exp: 32'hFF000000};
    vecs[3] = '{name: "tex3_load",  tex: 8'd3, ld: 1'b1, gt: 1'b0, exp: 32'h00FF0000};
    vecs[4] = '{name: "load_prio",  tex: 8'd2, ld: 1'b1, gt: 1'b1, exp: 32'hFF000000};
    vecs[5] = '{name: "get_next",   tex: 8'd3, ld: 1'b0, gt: 1'b1, exp: 32'hFF000000};

    #2 reset = 1'b1;
    #1 chk("reset_async", dut_word(), 32'h0);
    tick();
    tick();
    chk("reset_hold", dut_word(), 32'h0);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 50; i++)  wr(i, 32'hFFFFFFFF);
    for (int i = 50; i < 80; i++) wr(i, 32'hFF000000);
    for (int i = 80; i < 120; i++) wr(i, 32'h00FF0000);

    // Two-cycle load pulse re-fetches texel 0 each cycle
    TexNum = 8'd1;
    load_texture = 1'b1;
    tick();
    tick();
    chk("pulse_first", dut_word(), 32'hFFFFFFFF);
    load_texture = 1'b0;
    tick();
    chk("pulse_second", dut_word(), 32'hFFFFFFFF);

    foreach (vecs[i]) begin
      TexNum = vecs[i].tex;
      load_texture = vecs[i].ld;
      get_rgba = vecs[i].gt;
      tick();
      load_texture = 1'b0;
      get_rgba = 1'b0;
      tick();
      chk(vecs[i].name, dut_word(), vecs[i].exp);
    end

    // Streaming through words 50..52
    wr(50, 32'd1);
    wr(51, 32'd2);
    wr(52, 32'd3);
    TexNum = 8'd2;
    load_texture = 1'b1;
    tick();
    load_texture = 1'b0;
    get_rgba = 1'b1;
    tick();
    chk("stream_a1", {24'h0, alpha}, 32'd1);
    tick();
    chk("stream_a2", {24'h0, alpha}, 32'd2);
    get_rgba = 1'b0;
    tick();
    chk("stream_a3", {24'h0, alpha}, 32'd3);

    // End-of-slot behaviour
    wr(0, 32'h0A0B0C0D);
    wr(49, 32'h31313131);
    TexNum = 8'd1;
    load_texture = 1'b1;
    tick();
    load_texture = 1'b0;
    get_rgba = 1'b1;
    for (int i = 0; i < 49; i++) tick();
    tick();
    chk("slot_last_word", dut_word(), 32'h31313131);
    get_rgba = 1'b0;
    tick();
`ifdef TEXCTRL_PIXEL_WRAP_EN
    chk("slot_wrap", dut_word(), 32'h0A0B0C0D);
`else
    chk("slot_runon", dut_word(), 32'h00000001);
`endif

    // Same-word write during the fetch edge returns the old value
    TexNum = 8'd3;
    load_texture = 1'b1;
    tick();
    load_texture = 1'b0;
    write = 1'b1;
    write_address = 17'd100;
    write_data = 32'h12345678;
    tick();
    write = 1'b0;
    chk("read_first", dut_word(), 32'h00FF0000);

    // Write then fetch on the following edge sees the new data
    wr(101, 32'hCAFEF00D);
    get_rgba = 1'b1;
    tick();
    get_rgba = 1'b0;
    tick();
    chk("write_visible", dut_word(), 32'hCAFEF00D);

    // Out-of-range write is dropped and does not alias low words
    wr(MEM_DEPTH, 32'hDEADBEEF);
    TexNum = 8'd1;
    load_texture = 1'b1;
    tick();
    load_texture = 1'b0;
    tick();
    chk("oob_write_ignored", dut_word(), 32'h0A0B0C0D);

    // Reset in the middle of a stream
    TexNum = 8'd2;
    load_texture = 1'b1;
    tick();
    load_texture = 1'b0;
    get_rgba = 1'b1;
    tick();
    tick();
    #3 reset = 1'b1;
    #1 chk("midstream_rst_async", dut_word(), 32'h0);
    model_reset();
    get_rgba = 1'b0;
    tick();
    tick();
    chk("midstream_rst_hold", dut_word(), 32'h0);
    #2 reset = 1'b0;
    tick();
    chk("post_release_idle", dut_word(), 32'h0);

    // Pulse reset between request and fetch edges
    get_rgba = 1'b1;
    tick();
    get_rgba = 1'b0;
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    tick();
    chk("fetch_cancelled", dut_word(), 32'h0);

    TexNum = 8'd1;
    load_texture = 1'b1;
    tick();
    load_texture = 1'b0;
    tick();
    chk("reload_after_rst", dut_word(), 32'h0A0B0C0D);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
